dct_block_scheduler: RTL
========================

# dct_block_scheduler

Sequences the 8x8 2-D DCT engine over a stream of pixel blocks. Upstream fills two ping-pong source buffers; the 2-D DCT writes into two ping-pong coefficient buffers that downstream (quantizer/zigzag) drains. This block decides when the DCT runs, which buffers it reads and writes, when buffers are handed back, and raises a sticky fault if the engine hangs. Blocks leave in exactly the order they arrived.

## Interface
- `TIMEOUT_CYCLES`, default 2048: maximum RUN cycles before a hang fault is declared.
- `COUNT_W`, default 16: width of `blocks_done`.

Ports:
- `clock` in, 1 bit: the single clock.
- `reset` in, 1 bit: synchronous, active-high.
- `enable` in, 1 bit: permits new launches. An in-flight block always completes.
- `src_ready` in, 2 bits: bit i set means source buffer i holds a complete level-shifted block. Must stay high until the matching `src_release`.
- `src_release` out, 2 bits: one-cycle pulse on bit i when the DCT has finished reading buffer i.
- `src_sel` out, 1 bit: source buffer the DCT fetch mux reads.
- `dct_nreset` out, 1 bit: run/hold control to the 2-D DCT. Low holds the engine in reset.
- `dct_finished` in, 1 bit: engine completion level. Remains high while the engine is released.
- `dst_sel` out, 1 bit: coefficient buffer the DCT result writes target.
- `dst_valid` out, 2 bits: bit i set means coefficient buffer i holds a finished block.
- `dst_release` in, 2 bits: downstream pulse on bit i when it is done with buffer i.
- `busy` out, 1 bit: high in LAUNCH, RUN and RETIRE.
- `fault` out, 1 bit: sticky timeout flag. Cleared only by `reset`.
- `blocks_done` out, `COUNT_W` bits: count of retired blocks. Wraps.

## Operation
- Internal state:
  - `src_ptr` and `dst_ptr`: 1-bit each. They drive `src_sel` and `dst_sel` and toggle only in RETIRE.
  - Run timer.
  - State: IDLE, LAUNCH, RUN, RETIRE, FAULT.
- Launch condition: `enable && src_ready[src_ptr] && !dst_valid[dst_ptr]`. Only the buffer under the pointer is considered. The other buffer being ready never causes a launch, so ordering is preserved.
- IDLE → LAUNCH when the launch condition holds.
- LAUNCH (exactly 1 cycle):
  - `dct_nreset`=0, which clears the engine.
  - Timer is cleared.
  - Always → RUN.
- RUN:
  - `dct_nreset`=1; the timer increments each cycle.
  - `dct_finished` is ignored in the first RUN cycle (blanking) and sampled from the second cycle on.
  - `dct_finished` high → RETIRE.
  - Timer reaching `TIMEOUT_CYCLES-1` without `dct_finished` → FAULT.
- RETIRE (1 cycle):
  - `dct_nreset`=0.
  - `src_release[src_ptr]` pulses.
  - At the next edge: `dst_valid[dst_ptr]` is set, both pointers toggle, and `blocks_done` increments (wraps to 0 past all-ones).
  - Always → IDLE.
- FAULT (terminal until `reset`):
  - `dct_nreset`=0, `fault`=1.
  - No `src_release` is issued.
  - `dst_valid` still clears on `dst_release`.
- `dst_valid[i]` clears at the edge after `dst_release[i]`. A `dst_release` on a bit that is not valid is ignored. Releases of both bits in the same cycle are both honored.
- `src_ready` is not re-sampled after launch. Dropping it early is an upstream protocol violation with undefined data, but the FSM must not hang because of it.
- `enable` falling during LAUNCH, RUN or RETIRE has no effect until the block returns to IDLE.

## Timing
- Reset values: `dct_nreset`=0, `src_sel`=0, `dst_sel`=0, `src_release`=00, `dst_valid`=00, `busy`=0, `fault`=0, `blocks_done`=0. State is IDLE and both pointers are 0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Launch-condition true at edge N gives:
  - LAUNCH during cycle N+1.
  - RUN from N+2.
- `dct_finished` sampled high at edge M gives:
  - RETIRE in cycle M+1, with `src_release` high during that cycle.
  - `dst_valid` set and pointers toggled from M+2, which is also back in IDLE.
- Fixed scheduler overhead is 3 cycles per block (IDLE check, LAUNCH, RETIRE) plus the engine's run time.
- `src_sel` and `dst_sel` are stable from the start of LAUNCH through the end of RETIRE.
- A `reset` in any state aborts immediately: the engine is held, no release pulses are issued, and the counter is zeroed.

## Structure
- Shared package `jfpjc_dct_pkg` holds:
  - The state enum (IDLE/LAUNCH/RUN/RETIRE/FAULT).
  - `DCT_TIMER_W` = $clog2(`TIMEOUT_CYCLES`).
  - The 64-entry block-size constant shared with the DCT and quantizer.
- One natural sub-module, `dct_buffer_pingpong`, used twice:
  - It holds a 1-bit pointer and a 2-bit occupancy vector, with toggle, set and clear inputs.
  - Destination instance: `dst_valid` is its occupancy.
  - Source instance: occupancy is driven from `src_ready`.
- FSM, timer and counter live in the top level.

## Test plan
- Single block: reset, `enable`=1, `src_ready`=01, model finishes after 300 RUN cycles → one `src_release`=01 pulse, `dst_valid`=01, `blocks_done`=1, `src_sel`/`dst_sel` then read 1.
- Ordering: `src_ready`=10 only after reset → no launch. Then assert bit 0 → buffer 0 processed first, then buffer 1; `blocks_done`=2.
- Back-pressure: `dst_valid`=11 with `src_ready`=11 → stays IDLE, `dct_nreset`=0. Pulse `dst_release`=01 → launch within 2 cycles, writing `dst_sel`=0.
- Timeout: `TIMEOUT_CYCLES`=16, model never finishes → `fault`=1 after 16 RUN cycles, `dct_nreset`=0, no `src_release`, `busy`=0. Only `reset` clears `fault`.
- Stale finish: hold `dct_finished`=1 through LAUNCH and the first RUN cycle → no RETIRE in the first RUN cycle; RETIRE occurs on the second.
- Reset mid-RUN, then counter wrap: `reset` in RUN → all reset values the next cycle. Separately, with `COUNT_W`=2, retire 5 blocks → `blocks_done`=1.

Source files
------------

// File: rtl/jfpjc_dct_pkg.sv
// Shared definitions for the 8x8 DCT pipeline: scheduler states, sizing
// helpers and the block size shared with the DCT and quantizer.
package jfpjc_dct_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RETIRE,
    ST_FAULT
  } dct_state_e;

  localparam int unsigned DCT_TIMEOUT_CYCLES_DEF = 2048;
  localparam int unsigned DCT_BLOCK_SIZE         = 64;

  // Run-timer width for a given timeout; never narrower than one bit.
  function automatic int unsigned dct_timer_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int unsigned DCT_TIMER_W = dct_timer_width(DCT_TIMEOUT_CYCLES_DEF);

  // One-hot buffer mask for a 1-bit ping-pong selector.
  function automatic logic [1:0] buf_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dct_buffer_pingpong.sv
// Ping-pong buffer tracker: a 1-bit pointer plus a 2-bit occupancy vector.
// With OCC_IS_LEVEL the occupancy follows i_set as a level (masked by
// i_clear); otherwise it is a register set/cleared by pulses.
module dct_buffer_pingpong #(
  parameter bit OCC_IS_LEVEL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_toggle,
  input  logic [1:0] i_set,
  input  logic [1:0] i_clear,
  output logic       o_ptr,
  output logic [1:0] o_occ
);

  logic r_ptr;

  // Pointer flips once per retired block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_toggle) begin
      r_ptr <= ~r_ptr;
    end
  end

  assign o_ptr = r_ptr;

  generate
    if (OCC_IS_LEVEL) begin : g_level
      assign o_occ = i_set & ~i_clear;
    end else begin : g_reg
      logic [1:0] r_occ;

      // Set wins over a same-cycle clear, so a stray release never drops a fresh block.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_occ <= '0;
        end else begin
          r_occ <= (r_occ & ~i_clear) | i_set;
        end
      end

      assign o_occ = r_occ;
    end
  endgenerate

endmodule

// File: rtl/dct_block_scheduler.sv
// Sequences the 2-D DCT over ping-pong source/coefficient buffers, keeping
// blocks in arrival order and flagging a sticky fault if the engine hangs.
module dct_block_scheduler
  import jfpjc_dct_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DCT_TIMEOUT_CYCLES_DEF,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         src_ready,
  output logic [1:0]         src_release,
  output logic               src_sel,
  output logic               dct_nreset,
  input  logic               dct_finished,
  output logic               dst_sel,
  output logic [1:0]         dst_valid,
  input  logic [1:0]         dst_release,
  output logic               busy,
  output logic               fault,
  output logic [COUNT_W-1:0] blocks_done
);

  localparam int unsigned          TIMER_W    = dct_timer_width(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  dct_state_e         r_state;
  dct_state_e         w_next_state;
  logic [TIMER_W-1:0] r_timer;
  logic [COUNT_W-1:0] r_blocks_done;

  logic       w_src_ptr;
  logic [1:0] w_src_occ;
  logic       w_dst_ptr;
  logic [1:0] w_dst_occ;
  logic       w_retire;
  logic       w_launch;
  logic [1:0] w_dst_set;

  assign w_retire  = (r_state == ST_RETIRE);
  assign w_dst_set = w_retire ? buf_onehot(w_dst_ptr) : 2'b00;

  // Only the buffer under each pointer is considered, which preserves order.
  assign w_launch = enable && w_src_occ[w_src_ptr] && !w_dst_occ[w_dst_ptr];

  dct_buffer_pingpong #(
    .OCC_IS_LEVEL (1'b1)
  ) u_src_buf (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_toggle (w_retire),
    .i_set    (src_ready),
    .i_clear  (2'b00),
    .o_ptr    (w_src_ptr),
    .o_occ    (w_src_occ)
  );

  dct_buffer_pingpong #(
    .OCC_IS_LEVEL (1'b0)
  ) u_dst_buf (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_toggle (w_retire),
    .i_set    (w_dst_set),
    .i_clear  (dst_release),
    .o_ptr    (w_dst_ptr),
    .o_occ    (w_dst_occ)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a zero timer marks the blanked first RUN cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_launch) w_next_state = ST_LAUNCH;
      ST_LAUNCH: w_next_state = ST_RUN;
      ST_RUN: begin
        if ((r_timer != '0) && dct_finished) begin
          w_next_state = ST_RETIRE;
        end else if (r_timer == TIMER_LAST) begin
          w_next_state = ST_FAULT;
        end
      end
      ST_RETIRE: w_next_state = ST_IDLE;
      ST_FAULT:  w_next_state = ST_FAULT;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    dct_nreset  = (r_state == ST_RUN);
    busy        = (r_state == ST_LAUNCH) || (r_state == ST_RUN) || (r_state == ST_RETIRE);
    fault       = (r_state == ST_FAULT);
    src_release = w_retire ? buf_onehot(w_src_ptr) : 2'b00;
  end

  // Run timer: cleared in LAUNCH, counts every RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == ST_LAUNCH) begin
      r_timer <= '0;
    end else if (r_state == ST_RUN) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Retired-block counter, wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_blocks_done <= '0;
    end else if (w_retire) begin
      r_blocks_done <= r_blocks_done + 1'b1;
    end
  end

  assign src_sel     = w_src_ptr;
  assign dst_sel     = w_dst_ptr;
  assign dst_valid   = w_dst_occ;
  assign blocks_done = r_blocks_done;

endmodule
